// File: rtl/rf_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rf_pkg
// Description : Shared register-file constants and the write request type.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

   localparam int RF_ADDR_W   = 5;
   localparam int RF_DATA_W   = 32;
   localparam int RF_NUM_REGS = 32;
   localparam int RF_ZERO_REG = 0;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] addr;
      logic [RF_DATA_W-1:0] data;
   } rfWriteReq_t;

endpackage
`default_nettype wire

// File: rtl/rf_bypass_mux.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rf_bypass_mux
// Description : Forwards the pending write-stage data onto one read port.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_bypass_mux
   import rf_pkg::*;
#(
   parameter int ADDR_W             = RF_ADDR_W,
   parameter int DATA_W             = RF_DATA_W,
   parameter int ZERO_REG_HARDWIRED = 1
) (
   input  logic [ADDR_W-1:0] readAddress,
   input  logic [DATA_W-1:0] rfReadData,
   input  logic [ADDR_W-1:0] writeAddress,
   input  logic [DATA_W-1:0] writeData,
   input  logic              writeEn,
   output logic [DATA_W-1:0] readData
);

   logic w_zeroAddr;
   logic w_hit;

   // The zero register must read the file's value even if a stray enable appears.
   assign w_zeroAddr = (ZERO_REG_HARDWIRED != 0) && (readAddress == ADDR_W'(RF_ZERO_REG));
   assign w_hit      = writeEn && (readAddress == writeAddress) && !w_zeroAddr;
   assign readData   = w_hit ? writeData : rfReadData;

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rf_write_arbiter
// Description : Arbitrates ALU and load writebacks onto the register-file write
//               port, with ALU starvation guard and read-data bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int ADDR_W             = RF_ADDR_W,
   parameter int DATA_W             = RF_DATA_W,
   parameter int STARVE_LIMIT       = 4,
   parameter int ZERO_REG_HARDWIRED = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Hold,
   input  logic              AluReqValid,
   input  logic [ADDR_W-1:0] AluReqAddress,
   input  logic [DATA_W-1:0] AluReqData,
   output logic              AluReqReady,
   input  logic              MemReqValid,
   input  logic [ADDR_W-1:0] MemReqAddress,
   input  logic [DATA_W-1:0] MemReqData,
   output logic              MemReqReady,
   output logic [ADDR_W-1:0] WriteAddress,
   output logic [DATA_W-1:0] WriteData,
   output logic              ReadWriteEn,
   input  logic [ADDR_W-1:0] ReadAddress1,
   input  logic [ADDR_W-1:0] ReadAddress2,
   input  logic [DATA_W-1:0] RfReadData1,
   input  logic [DATA_W-1:0] RfReadData2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   output logic              AluStarved
);

   localparam int          c_CNT_W        = 4;
   localparam logic [3:0]  c_STARVE_LIMIT = STARVE_LIMIT[3:0];

   logic              w_aluGrant;
   logic              w_memGrant;
   logic              w_aluXfer;
   logic              w_anyXfer;
   logic [ADDR_W-1:0] w_winAddress;
   logic [DATA_W-1:0] w_winData;
   logic              w_winWrites;
   logic [c_CNT_W-1:0] w_starveNext;

   logic [c_CNT_W-1:0] r_starveCount;
   logic               r_aluStarved;
   logic [ADDR_W-1:0]  r_writeAddress;
   logic [DATA_W-1:0]  r_writeData;
   logic               r_writeEn;

   // Mem has priority; the registered starvation flag flips the tie-break.
   always_comb begin
      w_aluGrant = 1'b0;
      w_memGrant = 1'b0;
      if (!Hold) begin
         if (AluReqValid && MemReqValid) begin
            w_aluGrant = r_aluStarved;
            w_memGrant = !r_aluStarved;
         end else begin
            w_aluGrant = AluReqValid;
            w_memGrant = MemReqValid;
         end
      end
   end

   assign AluReqReady  = w_aluGrant;
   assign MemReqReady  = w_memGrant;
   assign w_aluXfer    = AluReqValid && w_aluGrant;
   assign w_anyXfer    = w_aluXfer || (MemReqValid && w_memGrant);
   assign w_winAddress = w_aluGrant ? AluReqAddress : MemReqAddress;
   assign w_winData    = w_aluGrant ? AluReqData    : MemReqData;
   assign w_winWrites  = !((ZERO_REG_HARDWIRED != 0) &&
                           (w_winAddress == ADDR_W'(RF_ZERO_REG)));

   // Held cycles count as waiting because the ALU is valid but not ready.
   always_comb begin
      w_starveNext = r_starveCount;
      if (!AluReqValid || w_aluXfer) begin
         w_starveNext = '0;
      end else if (r_starveCount != c_STARVE_LIMIT) begin
         w_starveNext = r_starveCount + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starveCount <= '0;
         r_aluStarved  <= 1'b0;
      end else begin
         r_starveCount <= w_starveNext;
         r_aluStarved  <= (w_starveNext == c_STARVE_LIMIT);
      end
   end

   // Address/data hold when idle so the register file sees stable ports.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_writeAddress <= '0;
         r_writeData    <= '0;
         r_writeEn      <= 1'b0;
      end else begin
         r_writeEn <= w_anyXfer && w_winWrites;
         if (w_anyXfer) begin
            r_writeAddress <= w_winAddress;
            r_writeData    <= w_winData;
         end
      end
   end

   assign WriteAddress = r_writeAddress;
   assign WriteData    = r_writeData;
   assign ReadWriteEn  = r_writeEn;
   assign AluStarved   = r_aluStarved;

   logic [1:0][ADDR_W-1:0] w_readAddress;
   logic [1:0][DATA_W-1:0] w_rfReadData;
   logic [1:0][DATA_W-1:0] w_readData;

   assign w_readAddress = {ReadAddress2, ReadAddress1};
   assign w_rfReadData  = {RfReadData2, RfReadData1};

   for (genvar gi = 0; gi < 2; gi++) begin : g_readPort
      rf_bypass_mux #(
         .ADDR_W             (ADDR_W),
         .DATA_W             (DATA_W),
         .ZERO_REG_HARDWIRED (ZERO_REG_HARDWIRED)
      ) u_bypass (
         .readAddress  (w_readAddress[gi]),
         .rfReadData   (w_rfReadData[gi]),
         .writeAddress (r_writeAddress),
         .writeData    (r_writeData),
         .writeEn      (r_writeEn),
         .readData     (w_readData[gi])
      );
   end

   assign ReadData1 = w_readData[0];
   assign ReadData2 = w_readData[1];

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Directed and random checks of rf_write_arbiter against an
//               architectural model (latest accepted value per register).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        Hold = 1'b0;
   logic        AluReqValid = 1'b0;
   logic [4:0]  AluReqAddress = '0;
   logic [31:0] AluReqData = '0;
   logic        AluReqReady;
   logic        MemReqValid = 1'b0;
   logic [4:0]  MemReqAddress = '0;
   logic [31:0] MemReqData = '0;
   logic        MemReqReady;
   logic [4:0]  WriteAddress;
   logic [31:0] WriteData;
   logic        ReadWriteEn;
   logic [4:0]  ReadAddress1 = '0;
   logic [4:0]  ReadAddress2 = '0;
   logic [31:0] RfReadData1;
   logic [31:0] RfReadData2;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic        AluStarved;

   // envRf stands in for register_file; mdlArch is what a reader should see.
   logic [31:0] envRf   [32];
   logic [31:0] mdlArch [32];

   assign RfReadData1 = envRf[ReadAddress1];
   assign RfReadData2 = envRf[ReadAddress2];

   int          nTests = 0;
   int          nFail  = 0;
   bit          expEn;
   logic [4:0]  expWA;
   logic [31:0] expWD;
   int          waitCnt;
   bit          lastAluAcc;
   bit          lastMemAcc;

   rf_write_arbiter #(
      .ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(LIMIT), .ZERO_REG_HARDWIRED(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .Hold(Hold),
      .AluReqValid(AluReqValid), .AluReqAddress(AluReqAddress),
      .AluReqData(AluReqData), .AluReqReady(AluReqReady),
      .MemReqValid(MemReqValid), .MemReqAddress(MemReqAddress),
      .MemReqData(MemReqData), .MemReqReady(MemReqReady),
      .WriteAddress(WriteAddress), .WriteData(WriteData), .ReadWriteEn(ReadWriteEn),
      .ReadAddress1(ReadAddress1), .ReadAddress2(ReadAddress2),
      .RfReadData1(RfReadData1), .RfReadData2(RfReadData2),
      .ReadData1(ReadData1), .ReadData2(ReadData2), .AluStarved(AluStarved)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nTests++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic setAlu(input bit v, input logic [4:0] a, input logic [31:0] d);
      AluReqValid = v; AluReqAddress = a; AluReqData = d;
   endtask

   task automatic setMem(input bit v, input logic [4:0] a, input logic [31:0] d);
      MemReqValid = v; MemReqAddress = a; MemReqData = d;
   endtask

   // One clock: check all outputs at the negedge, then advance the model.
   task automatic runCycle();
      bit          starved, gA, gM;
      int          nextWait;
      logic [4:0]  wa;
      logic [31:0] wd;
      @(negedge clk);
      starved = (waitCnt >= LIMIT);
      gA = 1'b0;
      gM = 1'b0;
      if (!Hold) begin
         if (AluReqValid && MemReqValid) begin
            if (starved) gA = 1'b1; else gM = 1'b1;
         end else if (AluReqValid) gA = 1'b1;
         else if (MemReqValid) gM = 1'b1;
      end
      check("aluReady", 32'(AluReqReady), 32'(gA));
      check("memReady", 32'(MemReqReady), 32'(gM));
      check("aluStarved", 32'(AluStarved), 32'(starved));
      check("writeEn", 32'(ReadWriteEn), 32'(expEn));
      check("writeAddr", 32'(WriteAddress), 32'(expWA));
      check("writeData", WriteData, expWD);
      check("readData1", ReadData1, mdlArch[ReadAddress1]);
      check("readData2", ReadData2, mdlArch[ReadAddress2]);
      if (!AluReqValid || gA) nextWait = 0;
      else nextWait = (waitCnt + 1 > LIMIT) ? LIMIT : waitCnt + 1;
      @(posedge clk);
      if (expEn) envRf[expWA] = expWD;
      waitCnt = nextWait;
      if (gA || gM) begin
         wa = gA ? AluReqAddress : MemReqAddress;
         wd = gA ? AluReqData : MemReqData;
         expWA = wa;
         expWD = wd;
         expEn = (wa != 5'd0);
         if (wa != 5'd0) mdlArch[wa] = wd;
      end else begin
         expEn = 1'b0;
      end
      lastAluAcc = gA;
      lastMemAcc = gM;
      #1;
   endtask

   // Called at posedge+1: reset lands mid-cycle and any pending write is dropped.
   task automatic midReset();
      #2;
      rst_n = 1'b0;
      setAlu(1'b0, 5'd0, 32'd0);
      setMem(1'b0, 5'd0, 32'd0);
      Hold = 1'b0;
      #1;
      check("rst_writeEn", 32'(ReadWriteEn), 32'd0);
      check("rst_writeAddr", 32'(WriteAddress), 32'd0);
      check("rst_writeData", WriteData, 32'd0);
      check("rst_aluStarved", 32'(AluStarved), 32'd0);
      check("rst_aluReady", 32'(AluReqReady), 32'd0);
      check("rst_memReady", 32'(MemReqReady), 32'd0);
      expEn = 1'b0; expWA = '0; expWD = '0; waitCnt = 0;
      lastAluAcc = 1'b0; lastMemAcc = 1'b0;
      for (int i = 0; i < 32; i++) mdlArch[i] = envRf[i];
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         envRf[i]   = $urandom;
         mdlArch[i] = envRf[i];
      end
      expEn = 1'b0; expWA = '0; expWD = '0; waitCnt = 0;
      lastAluAcc = 1'b0; lastMemAcc = 1'b0;

      #12;
      check("init_writeEn", 32'(ReadWriteEn), 32'd0);
      check("init_writeAddr", 32'(WriteAddress), 32'd0);
      check("init_aluStarved", 32'(AluStarved), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single ALU request, bypass before the register file is written
      setAlu(1'b1, 5'd8, 32'd294);
      ReadAddress1 = 5'd8;
      #1 check("single_ready", 32'(AluReqReady), 32'd1);
      runCycle();
      setAlu(1'b0, 5'd0, 32'd0);
      #1;
      check("single_wen", 32'(ReadWriteEn), 32'd1);
      check("single_waddr", 32'(WriteAddress), 32'd8);
      check("single_wdata", WriteData, 32'd294);
      check("single_bypass", ReadData1, 32'd294);
      runCycle();

      // Contention: Mem streams, ALU wins after LIMIT waiting cycles
      setAlu(1'b1, 5'd3, 32'h0000_aaaa);
      setMem(1'b1, 5'd4, 32'h1111_0000);
      for (int k = 0; k < LIMIT; k++) begin
         #1 check("cont_memReady", 32'(MemReqReady), 32'd1);
         runCycle();
         setMem(1'b1, 5'(5 + k), 32'h1111_0001 + 32'(k));
      end
      #1;
      check("cont_starved", 32'(AluStarved), 32'd1);
      check("cont_aluWins", 32'(AluReqReady), 32'd1);
      runCycle();
      setAlu(1'b0, 5'd0, 32'd0);
      #1 check("cont_memResume", 32'(MemReqReady), 32'd1);
      runCycle();
      check("cont_starveClear", 32'(AluStarved), 32'd0);
      setMem(1'b0, 5'd0, 32'd0);
      runCycle();

      // Same address: Mem lands first, ALU value wins in the end
      setAlu(1'b1, 5'd13, 32'd194);
      setMem(1'b1, 5'd13, 32'd48);
      ReadAddress1 = 5'd13;
      runCycle();
      setMem(1'b0, 5'd0, 32'd0);
      runCycle();
      setAlu(1'b0, 5'd0, 32'd0);
      runCycle();
      runCycle();
      check("sameaddr_final", ReadData1, 32'd194);

      // Zero register write is accepted but never visible
      setMem(1'b1, 5'd0, 32'd123);
      ReadAddress2 = 5'd0;
      #1 check("zero_ready", 32'(MemReqReady), 32'd1);
      runCycle();
      setMem(1'b0, 5'd0, 32'd0);
      #1;
      check("zero_wen", 32'(ReadWriteEn), 32'd0);
      check("zero_read", ReadData2, envRf[0]);
      runCycle();

      // Hold with both valid: pending write drains, starvation builds
      setAlu(1'b1, 5'd20, 32'h55);
      setMem(1'b1, 5'd21, 32'h66);
      runCycle();
      setMem(1'b1, 5'd22, 32'h77);
      Hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("hold_aluReady", 32'(AluReqReady), 32'd0);
         check("hold_memReady", 32'(MemReqReady), 32'd0);
         runCycle();
      end
      check("hold_starved", 32'(AluStarved), 32'd1);
      Hold = 1'b0;
      #1 check("hold_aluFirst", 32'(AluReqReady), 32'd1);
      runCycle();
      setAlu(1'b0, 5'd0, 32'd0);
      runCycle();
      setMem(1'b0, 5'd0, 32'd0);

      // Reset while a write is pending
      setAlu(1'b1, 5'd9, 32'hdead_beef);
      runCycle();
      midReset();
      runCycle();

      // Random traffic against the model
      for (int c = 0; c < 500; c++) begin
         if (!AluReqValid || lastAluAcc) begin
            if ($urandom_range(0, 3) != 0) setAlu(1'b1, 5'($urandom_range(0, 7)), $urandom);
            else setAlu(1'b0, 5'd0, 32'd0);
         end
         if (!MemReqValid || lastMemAcc) begin
            if ($urandom_range(0, 3) != 0) setMem(1'b1, 5'($urandom_range(0, 7)), $urandom);
            else setMem(1'b0, 5'd0, 32'd0);
         end
         Hold = ($urandom_range(0, 9) == 0);
         ReadAddress1 = 5'($urandom_range(0, 7));
         ReadAddress2 = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 99) == 0) midReset();
         else runCycle();
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single write port of register_file between two writeback requesters: ALU results and load (MEM) results.
- Each requester uses a valid/ready handshake. Mem has fixed priority, with a starvation guard for the ALU.
- One winner per cycle goes into a registered write stage that drives WriteAddress/WriteData/ReadWriteEn.
- Read data is bypassed so reads see the write still pending in that stage.

Parameters:
- ADDR_W, 5, register address width (32 registers).
- DATA_W, 32, register data width.
- STARVE_LIMIT, 4, consecutive ALU-waiting cycles after which the ALU wins the next arbitration (legal range 1..15).
- ZERO_REG_HARDWIRED, 1, when 1 a write to address 0 is accepted but never reaches the register file or the bypass.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- Hold  in  1  freezes arbitration (no grants) while high
- AluReqValid  in  1  ALU write request
- AluReqAddress  in  ADDR_W  ALU destination register
- AluReqData  in  DATA_W  ALU result
- AluReqReady  out  1  ALU request accepted this cycle
- MemReqValid  in  1  load write request
- MemReqAddress  in  ADDR_W  load destination register
- MemReqData  in  DATA_W  load data
- MemReqReady  out  1  load request accepted this cycle
- WriteAddress  out  ADDR_W  to register_file
- WriteData  out  DATA_W  to register_file
- ReadWriteEn  out  1  to register_file write enable
- ReadAddress1  in  ADDR_W  read port 1 address (also driven to register_file)
- ReadAddress2  in  ADDR_W  read port 2 address
- RfReadData1  in  DATA_W  raw register_file ReadData1
- RfReadData2  in  DATA_W  raw register_file ReadData2
- ReadData1  out  DATA_W  bypassed read data 1
- ReadData2  out  DATA_W  bypassed read data 2
- AluStarved  out  1  starvation override armed

Behaviour:
- Reset (async, rst_n=0):
  - WriteAddress=0, WriteData=0, ReadWriteEn=0.
  - Starvation counter=0, AluStarved=0.
  - Readies are combinational and therefore 0 while valids are 0.
- Arbitration (combinational, same cycle):
  - Hold=1: both readies are 0.
  - Otherwise, if only one valid is high, that requester is granted.
  - If both are valid: Mem is granted, unless AluStarved=1, in which case the ALU is granted.
  - Ready is high only for the granted requester. A transfer occurs when valid&ready. Ready may depend on valid.
- Starvation counter, per cycle:
  - Increments (saturating at STARVE_LIMIT) when AluReqValid=1 and AluReqReady=0.
  - Clears to 0 on any ALU transfer, or when AluReqValid=0.
  - AluStarved = (counter == STARVE_LIMIT), registered value.
  - Hold cycles count as ALU waiting.
- Write stage, updated every posedge:
  - On a transfer: WriteAddress/WriteData take the winner's values. ReadWriteEn=1, except 0 when ZERO_REG_HARDWIRED and the address is 0.
  - With no transfer: ReadWriteEn=0; WriteAddress/WriteData hold their previous values.
  - Latency: accepted at edge N, visible on register_file ports after N, written into the register file at edge N+1.
- Bypass (combinational):
  - ReadDataK = WriteData when ReadWriteEn=1 and ReadAddressK==WriteAddress; otherwise RfReadDataK.
  - With ZERO_REG_HARDWIRED, address 0 is never bypassed.
  - Both ports bypass independently, and both may hit the same entry.
- Same-address requests in the same cycle: only the winner is written this cycle. The loser is granted in a later cycle, so its write lands after the winner's.
- Hold asserted mid-stream:
  - The pending write stage still completes: ReadWriteEn for an entry accepted before Hold remains 1 for one cycle.
  - No new grants are issued until Hold=0.
- Reset mid-operation clears the pending write; that write is lost.
- Requesters must hold valid, address and data stable until accepted.

Decomposition:
- Shared package rf_pkg: constants RF_ADDR_W=5, RF_DATA_W=32, RF_NUM_REGS=32, RF_ZERO_REG=0; typedef for the write request struct {addr, data}.
- One natural sub-module: rf_bypass_mux (address-compare and select for a single read port), instantiated twice. Arbitration, starvation counter and the write stage stay in the top.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> ReadWriteEn=0, WriteAddress=0, WriteData=0, AluStarved=0 immediately, without waiting for a clock edge.
- Single requester: AluReqValid with addr 8, data 294 -> AluReqReady=1 the same cycle; next cycle ReadWriteEn=1, WriteAddress=8, WriteData=294; ReadAddress1=8 returns 294 via bypass before the register file is updated.
- Contention and starvation (STARVE_LIMIT=4): both valid continuously, Mem issues new requests every cycle -> Mem granted for 4 cycles, AluStarved=1, ALU granted on the 5th cycle, counter clears, Mem resumes.
- Same address: ALU (13, 194) and MEM (13, 48) both valid -> MEM written first, then ALU. A subsequent read of 13 returns 194.
- Zero register: MEM write (0, 123) -> MemReqReady=1, ReadWriteEn stays 0, ReadAddress2=0 returns RfReadData2 (not 123).
- Hold: Hold=1 for 3 cycles with both valid -> both readies 0, AluStarved rises once the counter reaches the limit. On release, the ALU is granted first.
